// File: rtl/accum_pkg.sv
// Shared types and helpers for the stream accumulator and later multi-stage reduction blocks.
package accum_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam int SEXT_MAX = 64;

  // Output width that cannot overflow for a frame of up to 2**count_width samples.
  function automatic int accum_width(input int in_width, input int count_width);
    return in_width + count_width;
  endfunction

  function automatic logic [SEXT_MAX-1:0] sext_to(input logic [SEXT_MAX-1:0] value,
                                                  input int width);
    int sh;
    sh = SEXT_MAX - width;
    return $signed(value << sh) >>> sh;
  endfunction

endpackage

// File: rtl/registered_stream_accumulator.sv
// Accumulates frames of len valid samples from the registered adder stream into one signed total.
module registered_stream_accumulator
  import accum_pkg::*;
#(
  parameter int IN_WIDTH    = 11,
  parameter int COUNT_WIDTH = 8,
  parameter int OUT_WIDTH   = accum_width(IN_WIDTH, COUNT_WIDTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        inReady,
  input  logic signed [IN_WIDTH-1:0]  in,
  input  logic [COUNT_WIDTH-1:0]      len,
  input  logic                        clear,
  output logic                        outReady,
  output logic signed [OUT_WIDTH-1:0] out,
  output logic                        busy,
  output logic                        earlyOutReady
);

  state_t                       state_r;
  logic signed [OUT_WIDTH-1:0]  acc_r;
  logic [COUNT_WIDTH-1:0]       cnt_r;
  logic [COUNT_WIDTH-1:0]       len_q_r;

  logic signed [OUT_WIDTH-1:0]  sext_in_s;
  logic [COUNT_WIDTH-1:0]       len_eff_s;
  logic                         last_s;

  assign sext_in_s = OUT_WIDTH'(sext_to(SEXT_MAX'(in), IN_WIDTH));
  assign len_eff_s = (len == {COUNT_WIDTH{1'b0}}) ? COUNT_WIDTH'(1) : len;

  // Whether a sample presented now would close its frame.
  always_comb begin
    last_s = 1'b0;
    case (state_r)
      IDLE:    last_s = (len_eff_s == COUNT_WIDTH'(1));
      ACCUM:   last_s = (cnt_r == len_q_r - COUNT_WIDTH'(1));
      default: last_s = 1'b0;
    endcase
  end

  assign earlyOutReady = inReady && last_s;

  // Frame state machine with accumulator, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= IDLE;
      acc_r    <= {OUT_WIDTH{1'b0}};
      cnt_r    <= {COUNT_WIDTH{1'b0}};
      len_q_r  <= {COUNT_WIDTH{1'b0}};
      outReady <= 1'b0;
      out      <= {OUT_WIDTH{1'b0}};
      busy     <= 1'b0;
    end else if (enable) begin
      outReady <= 1'b0;
      if (clear) begin
        // Abort drops any coincident sample; the last completed sum stays on out.
        state_r <= IDLE;
        acc_r   <= {OUT_WIDTH{1'b0}};
        cnt_r   <= {COUNT_WIDTH{1'b0}};
        busy    <= 1'b0;
      end else if (inReady) begin
        case (state_r)
          IDLE: begin
            len_q_r <= len_eff_s;
            if (len_eff_s == COUNT_WIDTH'(1)) begin
              out      <= sext_in_s;
              outReady <= 1'b1;
              busy     <= 1'b0;
            end else begin
              acc_r   <= sext_in_s;
              cnt_r   <= COUNT_WIDTH'(1);
              state_r <= ACCUM;
              busy    <= 1'b1;
            end
          end
          ACCUM: begin
            if (last_s) begin
              out      <= acc_r + sext_in_s;
              outReady <= 1'b1;
              cnt_r    <= {COUNT_WIDTH{1'b0}};
              state_r  <= IDLE;
              busy     <= 1'b0;
            end else begin
              acc_r <= acc_r + sext_in_s;
              cnt_r <= cnt_r + COUNT_WIDTH'(1);
            end
          end
          default: begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end else begin
      outReady <= outReady;
    end
  end

endmodule

// File: tb/tb_registered_stream_accumulator.sv
// Directed scoreboard bench for registered_stream_accumulator.
module tb_registered_stream_accumulator;

  localparam int IN_W  = 11;
  localparam int CNT_W = 8;
  localparam int OUT_W = IN_W + CNT_W;

  logic                    clk;
  logic                    reset;
  logic                    enable;
  logic                    inReady;
  logic signed [IN_W-1:0]  in_s;
  logic [CNT_W-1:0]        len;
  logic                    clear;
  logic                    outReady;
  logic signed [OUT_W-1:0] out;
  logic                    busy;
  logic                    earlyOutReady;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  longint exp_q[$];
  logic   m_busy  = 1'b0;
  logic   m_pulse = 1'b0;
  longint m_acc   = 0;
  longint m_out   = 0;
  int     m_cnt   = 0;
  int     m_len   = 0;

  registered_stream_accumulator #(
    .IN_WIDTH(IN_W),
    .COUNT_WIDTH(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .inReady(inReady),
    .in(in_s),
    .len(len),
    .clear(clear),
    .outReady(outReady),
    .out(out),
    .busy(busy),
    .earlyOutReady(earlyOutReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs, check the combinational flag, advance model, check registers.
  task automatic cyc(input logic rs, input logic en, input logic ir, input logic cl,
                     input int v, input int ln);
    logic exp_early;
    logic pop_now;
    reset   = rs;
    enable  = en;
    inReady = ir;
    clear   = cl;
    in_s    = IN_W'(v);
    len     = CNT_W'(ln);
    #1;
    if (rs) begin
      exp_early = ir && (m_busy ? (m_cnt == m_len - 1) : (ln == 0 || ln == 1));
      check("earlyOutReady", {63'd0, earlyOutReady}, {63'd0, exp_early});
    end
    pop_now = 1'b0;
    if (!rs) begin
      m_busy = 1'b0; m_pulse = 1'b0; m_acc = 0; m_out = 0; m_cnt = 0; m_len = 0;
      exp_q.delete();
    end else if (en) begin
      m_pulse = 1'b0;
      if (cl) begin
        m_busy = 1'b0; m_acc = 0; m_cnt = 0;
      end else if (ir) begin
        if (!m_busy) begin
          m_len = (ln == 0) ? 1 : ln;
          if (m_len == 1) begin
            exp_q.push_back(longint'(v));
            m_pulse = 1'b1;
          end else begin
            m_acc = v; m_cnt = 1; m_busy = 1'b1;
          end
        end else if (m_cnt == m_len - 1) begin
          exp_q.push_back(m_acc + v);
          m_pulse = 1'b1; m_cnt = 0; m_busy = 1'b0;
        end else begin
          m_acc = m_acc + v; m_cnt = m_cnt + 1;
        end
      end
      pop_now = m_pulse;
    end
    @(posedge clk);
    #1;
    check("outReady", {63'd0, outReady}, {63'd0, m_pulse});
    check("busy", {63'd0, busy}, {63'd0, m_busy});
    if (pop_now) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 64'sd1, 64'sd0);
      end else begin
        m_out = exp_q.pop_front();
      end
    end
    check("out", out, m_out);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; inReady = 1'b0; clear = 1'b0; in_s = '0; len = '0;

    // Reset with a valid sample presented; second cycle also has enable low.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 5, 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 5, 1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 4);

    // Basic frame of four: 3 - 1 + 7 + 2 = 11.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 3, 4);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, -1, 4);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 7, 4);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 2, 4);
    check("basic_sum", out, 64'sd11);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 4);

    // Gaps, enable stall and mid-frame len change: 100 + 200 - 50 = 250.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 100, 3);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 3);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 3);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 200, 7);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 999, 7);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, -50, 7);
    check("gap_sum", out, 64'sd250);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 7);   // stalled pulse must hold
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 7);

    // Single-sample frames with the most negative input.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, -1024, 0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, -1024, 0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, -1024, 1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, -1024, 1);
    check("len1_sum", out, -64'sd1024);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1);

    // Longest frame with maximal positive samples.
    for (int i = 0; i < 255; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1023, 255);
    check("len255_sum", out, 64'sd260865);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 255);

    // Back-to-back pairs 1..6 -> 3, 7, 11.
    for (int i = 1; i <= 6; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, i, 2);
    check("b2b_last", out, 64'sd11);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 2);

    // Abort with coincident sample, then a clean frame of ones.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 10, 4);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 20, 4);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 30, 4);
    check("abort_out_kept", out, 64'sd11);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1, 4);
    check("after_abort_sum", out, 64'sd4);

    // Reset mid-frame discards the partial sum.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 5, 3);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 6, 3);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 7, 3);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 3);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 9, 2);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, -4, 2);
    check("post_reset_sum", out, 64'sd5);

    check("scoreboard_empty", longint'(exp_q.size()), 64'sd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
